rs_decoder_line_packer: RTL and testbench

RS_DECODER_LINE_PACKER -- requirements
Module: rs_decoder_line_packer

---
 rtl/rs_decoder_line_packer.sv | 114 +++++++++++
 tb/tb_rs_decoder_line_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rs_decoder_line_packer.sv
// Packs decoded RS bytes into LINE_BYTES-wide lines and queues them in a
// first-word-fall-through FIFO. Lines that arrive while the FIFO is full are dropped and counted.
module rs_decoder_line_packer #(
    parameter int LINE_BYTES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              data_in,
    input  logic                    valid_in,
    input  logic                    flush,
    input  logic                    clear_overflow,
    output logic [LINE_BYTES*8-1:0] line_data,
    output logic [6:0]              line_bytes,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic [2:0]              fifo_count,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int LW = LINE_BYTES * 8;
    localparam int IW = $clog2(LINE_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] idx;
    logic [LW-1:0] asmLine;
    logic [LW-1:0] newByte;
    logic [LW-1:0] pushLine;
    logic [6:0]    pushBytes;
    logic          lastByte;
    logic          pushReq;

    logic [LW-1:0] memLine  [FIFO_DEPTH];
    logic [6:0]    memBytes [FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          doWrite;
    logic          drop;

    // The line leaving the assembler always includes the byte arriving this cycle.
    assign lastByte  = valid_in && (idx == IW'(LINE_BYTES - 1));
    assign pushReq   = lastByte || (flush && (valid_in || (idx != '0)));
    assign newByte   = LW'(data_in) << {idx, 3'b000};
    assign pushLine  = valid_in ? (asmLine | newByte) : asmLine;
    assign pushBytes = 7'(idx) + {6'b0, valid_in};

    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = line_valid && line_ready;
    assign doWrite = pushReq && (!full || pop);
    assign drop    = pushReq && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            asmLine <= '0;
        end else if (pushReq) begin
            idx     <= '0;
            asmLine <= '0;
        end else if (valid_in) begin
            idx     <= idx + 1'b1;
            asmLine <= asmLine | newByte;
        end
    end

    // NOTE: the line storage has no reset; outputs are gated by line_valid,
    // so stale contents are never observable and the wide array stays plain RAM.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            memLine[wrPtr]  <= pushLine;
            memBytes[wrPtr] <= pushBytes;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (pop)     rdPtr <= rdPtr + 1'b1;
            if (doWrite && !pop)      count <= count + 1'b1;
            else if (!doWrite && pop) count <= count - 1'b1;
        end
    end

    // A drop on the same edge as a clear wins, leaving exactly one recorded drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (clear_overflow)             drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign line_valid = (count != '0);
    assign line_data  = line_valid ? memLine[rdPtr] : '0;
    assign line_bytes = line_valid ? memBytes[rdPtr] : '0;
    assign fifo_count = 3'(count);

endmodule

// File: tb/tb_rs_decoder_line_packer.sv
// Directed bench for rs_decoder_line_packer: full lines, flushes, overflow,
// simultaneous push/pop when full, and asynchronous reset mid-line.
module tb_rs_decoder_line_packer;

    localparam int LB = 64;
    localparam int LW = LB * 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    data_in = '0;
    logic          valid_in = 1'b0;
    logic          flush = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [LW-1:0] line_data;
    logic [6:0]    line_bytes;
    logic          line_valid;
    logic          line_ready = 1'b0;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic [15:0]   drop_count;

    int nChecks = 0;
    int nErrors = 0;

    rs_decoder_line_packer #(.LINE_BYTES(LB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
        .flush(flush), .clear_overflow(clear_overflow), .line_data(line_data),
        .line_bytes(line_bytes), .line_valid(line_valid), .line_ready(line_ready),
        .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(int n, int k);
        return 8'(n * 50 + k);
    endfunction

    function automatic logic [LW-1:0] patLine(int n);
        logic [LW-1:0] l;
        for (int k = 0; k < LB; k++) l[8*k +: 8] = pat(n, k);
        return l;
    endfunction

    // Drive one clock cycle of inputs; returns 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic f,
                       input logic rdy, input logic clr);
        @(negedge clk);
        valid_in = v; data_in = d; flush = f; line_ready = rdy; clear_overflow = clr;
        @(posedge clk);
        #1;
        valid_in = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
    endtask

    task automatic feedLine(input int n, input logic rdy, input logic lastRdy, input logic lastClr);
        for (int k = 0; k < LB - 1; k++) cyc(1'b1, pat(n, k), 1'b0, rdy, 1'b0);
        cyc(1'b1, pat(n, LB - 1), 1'b0, lastRdy, lastClr);
        line_ready = 1'b0;
    endtask

    task automatic drainExpect(input int n);
        check($sformatf("drain%0d_valid", n), LW'(line_valid), LW'(1));
        check($sformatf("drain%0d_data", n), line_data, patLine(n));
        check($sformatf("drain%0d_bytes", n), LW'(line_bytes), LW'(64));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        line_ready = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] exp;

        // Reset state
        #12;
        check("rst_valid", LW'(line_valid), LW'(0));
        check("rst_count", LW'(fifo_count), LW'(0));
        check("rst_data", line_data, '0);
        check("rst_bytes", LW'(line_bytes), LW'(0));
        check("rst_ovf", LW'(overflow), LW'(0));
        check("rst_drop", LW'(drop_count), LW'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Full line 0x00..0x3F with line_ready held high
        for (int k = 0; k < LB - 1; k++) cyc(1'b1, 8'(k), 1'b0, 1'b1, 1'b0);
        check("l0_not_yet", LW'(line_valid), LW'(0));
        cyc(1'b1, 8'(LB - 1), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < LB; k++) exp[8*k +: 8] = 8'(k);
        check("l0_valid", LW'(line_valid), LW'(1));
        check("l0_data", line_data, exp);
        check("l0_bytes", LW'(line_bytes), LW'(64));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("l0_one_cycle", LW'(line_valid), LW'(0));

        // Partial line of 10 bytes then flush
        for (int k = 0; k < 10; k++) cyc(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 1'b0);
        check("part_pending", LW'(line_valid), LW'(0));
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        exp = '0;
        for (int k = 0; k < 10; k++) exp[8*k +: 8] = 8'(8'hA0 + k);
        check("part_valid", LW'(line_valid), LW'(1));
        check("part_bytes", LW'(line_bytes), LW'(10));
        check("part_data", line_data, exp);
        check("part_count", LW'(fifo_count), LW'(1));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("part_popped", LW'(fifo_count), LW'(0));

        // Flush with nothing assembled does nothing
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("idle_flush_count", LW'(fifo_count), LW'(0));
        check("idle_flush_valid", LW'(line_valid), LW'(0));

        // Flush together with a valid byte includes that byte
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        check("vflush_bytes", LW'(line_bytes), LW'(3));
        check("vflush_data", line_data, LW'(24'h332211));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("vflush_popped", LW'(fifo_count), LW'(0));

        // Five lines with no reader: the fifth is dropped
        for (int n = 0; n < 4; n++) feedLine(n, 1'b0, 1'b0, 1'b0);
        check("fill_count", LW'(fifo_count), LW'(4));
        check("fill_ovf", LW'(overflow), LW'(0));
        feedLine(4, 1'b0, 1'b0, 1'b0);
        check("drop_count_full", LW'(fifo_count), LW'(4));
        check("drop_ovf", LW'(overflow), LW'(1));
        check("drop_cnt", LW'(drop_count), LW'(1));
        for (int n = 0; n < 4; n++) drainExpect(n);
        check("drained_valid", LW'(line_valid), LW'(0));
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", LW'(overflow), LW'(0));
        check("clr_cnt", LW'(drop_count), LW'(0));

        // Drop coinciding with clear, then push+pop while full
        for (int n = 10; n < 14; n++) feedLine(n, 1'b0, 1'b0, 1'b0);
        feedLine(14, 1'b0, 1'b0, 1'b0);
        check("drop2_cnt", LW'(drop_count), LW'(1));
        feedLine(15, 1'b0, 1'b0, 1'b1);
        check("dropclr_ovf", LW'(overflow), LW'(1));
        check("dropclr_cnt", LW'(drop_count), LW'(1));
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr2_ovf", LW'(overflow), LW'(0));
        feedLine(16, 1'b0, 1'b1, 1'b0);
        check("pushpop_count", LW'(fifo_count), LW'(4));
        check("pushpop_ovf", LW'(overflow), LW'(0));
        check("pushpop_cnt", LW'(drop_count), LW'(0));
        drainExpect(11);
        drainExpect(12);
        drainExpect(13);
        drainExpect(16);
        check("drained2_valid", LW'(line_valid), LW'(0));

        // Asynchronous reset mid-line with a line queued
        feedLine(20, 1'b0, 1'b0, 1'b0);
        check("prerst_valid", LW'(line_valid), LW'(1));
        for (int k = 0; k < 30; k++) cyc(1'b1, pat(21, k), 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", LW'(line_valid), LW'(0));
        check("arst_count", LW'(fifo_count), LW'(0));
        check("arst_data", line_data, '0);
        check("arst_bytes", LW'(line_bytes), LW'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < LB; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < LB; k++) exp[8*k +: 8] = 8'(8'h40 + k);
        check("postrst_valid", LW'(line_valid), LW'(1));
        check("postrst_count", LW'(fifo_count), LW'(1));
        check("postrst_bytes", LW'(line_bytes), LW'(64));
        check("postrst_data", line_data, exp);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
